// File: rtl/ins_check_queue_pkg.sv
// Shared types and constants for the fetch-stage instruction checker.
// Control words carry the prefix 6'b111111 followed by a 2-bit subcode.
package ins_check_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2,
    DONE = 2'd3
  } run_state_t;

  localparam logic [5:0] CTRL_PREFIX = 6'b111111;
  localparam logic [1:0] SUB_START   = 2'b10;
  localparam logic [1:0] SUB_STOP    = 2'b11;
  localparam logic [1:0] SUB_END     = 2'b00;
  localparam logic [1:0] SUB_RSVD    = 2'b01;

endpackage

// File: rtl/ins_check_queue_if.sv
// Instruction handshake bundle: fetch side (ins_in/valid/ready_out) and
// control-unit side (ins_out/valid_out/ready_in).
// The checker uses the slave modport; the fetch/CU environment uses master.
interface ins_check_queue_if #(
  parameter int BUS_W = 32
) ();

  logic [BUS_W-1:0] ins_in;
  logic             ins_valid_in;
  logic             ins_ready_out;
  logic [BUS_W-1:0] ins_out;
  logic             ins_valid_out;
  logic             ins_ready_in;

  modport master (
    output ins_in, ins_valid_in, ins_ready_in,
    input  ins_ready_out, ins_out, ins_valid_out
  );

  modport slave (
    input  ins_in, ins_valid_in, ins_ready_in,
    output ins_ready_out, ins_out, ins_valid_out
  );

endinterface

// File: rtl/ins_check_queue_fifo.sv
// Synchronous FIFO for ordinary instructions. Pointers carry one extra
// wrap bit so full and empty are distinguished without a counter.
// The head is read combinationally so a word pushed into an empty FIFO
// is visible on the very next cycle.
module ins_fifo #(
  parameter int BUS_W = 32,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [BUS_W-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [BUS_W-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [BUS_W-1:0] mem_q [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointers: flush wins over any push/pop in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push && !full)  wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop  && !empty) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Pointer registers; reset empties the queue.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (push && !full && !flush) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ins_check_queue.sv
// Fetch-stage instruction checker. Control words (prefix 6'b111111) drive
// the run-control FSM; ordinary words are queued and issued to the CU.
// Optional build macro INS_ILLEGAL_DETECT_EN adds a sticky illegal_out flag
// for reserved control words and for ordinary words arriving in DONE.
module ins_check_queue
  import ins_check_pkg::*;
#(
  parameter int BUS_W      = 32,
  parameter int SIG_W      = 19,
  parameter int DEPTH      = 4,
  parameter int COMM_PULSE = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  ins_check_queue_if.slave bus,
  output logic [SIG_W-1:0] signal_out,
  output logic             pc_choice_out,
  output logic             cu_enable_out,
  output logic             communication_enable_out,
  output logic [1:0]       state_out
`ifdef INS_ILLEGAL_DETECT_EN
  ,
  output logic             illegal_out
`endif
);

  localparam int PW = $clog2(COMM_PULSE + 1);

  run_state_t       state_q, state_d;
  logic [SIG_W-1:0] signal_q, signal_d;
  logic             pc_choice_q, pc_choice_d;
  logic             comm_hold_q, comm_hold_d;
  logic [PW-1:0]    pulse_cnt_q, pulse_cnt_d;

  logic             fifo_full, fifo_empty, fifo_flush;
  logic [BUS_W-1:0] fifo_head;
  logic             ready, accept, is_ctrl, ctrl_acc, ord_acc;
  logic             push, pop, issue_valid;
  logic [1:0]       sub;
  logic [SIG_W-1:0] field;

  // Ready depends only on registered state, never on ins_ready_in.
  assign ready       = (state_q == DONE) || !fifo_full;
  assign accept      = bus.ins_valid_in && ready;
  assign is_ctrl     = (bus.ins_in[BUS_W-1 -: 6] == CTRL_PREFIX);
  assign sub         = bus.ins_in[BUS_W-7 -: 2];
  assign field       = bus.ins_in[BUS_W-7 -: SIG_W];
  assign ctrl_acc    = accept && is_ctrl;
  assign ord_acc     = accept && !is_ctrl;
  assign push        = ord_acc && (state_q != DONE);
  assign issue_valid = (state_q == RUN) && !fifo_empty;
  assign pop         = issue_valid && bus.ins_ready_in;

  assign bus.ins_ready_out = ready;
  assign bus.ins_valid_out = issue_valid;
  assign bus.ins_out       = fifo_empty ? '0 : fifo_head;

  assign signal_out               = signal_q;
  assign pc_choice_out            = pc_choice_q;
  assign cu_enable_out            = (state_q == RUN);
  assign communication_enable_out = comm_hold_q || (pulse_cnt_q != '0);
  assign state_out                = state_q;

  ins_fifo #(
    .BUS_W (BUS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (fifo_flush),
    .din     (bus.ins_in),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

  // Run-control next state: control words act on the following cycle.
  always_comb begin
    state_d     = state_q;
    signal_d    = signal_q;
    pc_choice_d = pc_choice_q;
    comm_hold_d = comm_hold_q;
    pulse_cnt_d = (pulse_cnt_q != '0) ? pulse_cnt_q - PW'(1) : '0;
    fifo_flush  = 1'b0;

    // The held strobe drops once the first instruction reaches the CU.
    if (pop) comm_hold_d = 1'b0;

    if (ctrl_acc) begin
      case (sub)
        SUB_START: begin
          signal_d = field;
          if (state_q == IDLE || state_q == HALT) begin
            state_d     = RUN;
            pc_choice_d = 1'b0;
            comm_hold_d = 1'b1;
          end
        end
        SUB_STOP: begin
          signal_d = field;
          if (state_q != DONE) begin
            pulse_cnt_d = PW'(COMM_PULSE);
            comm_hold_d = 1'b0;
            if (state_q == RUN) state_d = HALT;
          end
        end
        SUB_END: begin
          signal_d = field;
          if (state_q != DONE) begin
            state_d     = DONE;
            fifo_flush  = 1'b1;
            comm_hold_d = 1'b1;
            pulse_cnt_d = '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Run-control registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      signal_q    <= '0;
      pc_choice_q <= 1'b1;
      comm_hold_q <= 1'b0;
      pulse_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      signal_q    <= signal_d;
      pc_choice_q <= pc_choice_d;
      comm_hold_q <= comm_hold_d;
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

`ifdef INS_ILLEGAL_DETECT_EN
  logic illegal_q, illegal_d;

  assign illegal_out = illegal_q;

  // Sticky flag for reserved control words and ordinary words after end.
  always_comb begin
    illegal_d = illegal_q;
    if ((ctrl_acc && sub == SUB_RSVD) || (ord_acc && state_q == DONE))
      illegal_d = 1'b1;
  end

  // Illegal flag register, cleared only by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) illegal_q <= 1'b0;
    else          illegal_q <= illegal_d;
  end
`endif

endmodule

// File: tb/tb_ins_check_queue.sv
// Directed bench for ins_check_queue with a scoreboard of expected issues.
// Honours INS_ILLEGAL_DETECT_EN when the design is built with it.
module tb_ins_check_queue;
  import ins_check_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [18:0] signal_out;
  logic        pc_choice_out, cu_enable_out, communication_enable_out;
  logic [1:0]  state_out;
`ifdef INS_ILLEGAL_DETECT_EN
  logic        illegal_out;
`endif

  ins_check_queue_if #(.BUS_W(32)) bus ();

  ins_check_queue #(
    .BUS_W(32), .SIG_W(19), .DEPTH(4), .COMM_PULSE(2)
  ) dut (
    .clock                    (clock),
    .reset_n                  (reset_n),
    .bus                      (bus),
    .signal_out               (signal_out),
    .pc_choice_out            (pc_choice_out),
    .cu_enable_out            (cu_enable_out),
    .communication_enable_out (communication_enable_out),
    .state_out                (state_out)
`ifdef INS_ILLEGAL_DETECT_EN
    ,
    .illegal_out              (illegal_out)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [31:0] exp_q[$];
  int          issue_cyc[$];

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every CU handshake is matched against the expected-issue queue.
  always @(negedge clock) begin
    if (reset_n && bus.ins_valid_out && bus.ins_ready_in) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_issue: got %h required no issue", bus.ins_out);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (bus.ins_out !== e) begin
          bad++;
          $display("FAIL issue_word: got %h required %h", bus.ins_out, e);
        end else begin
          $display("issue %h at cycle %0d", bus.ins_out, cyc);
        end
      end
      issue_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Control word: prefix, subcode, 17 low signal bits, 7 zero bits.
  // The signal field [25:7] is therefore {sub, low}.
  function automatic logic [31:0] ctrl(input logic [1:0] s, input logic [16:0] low);
    return {6'h3F, s, low, 7'h00};
  endfunction

  // Called 1 time unit after a rising edge; returns 1 unit after the
  // edge at which the word was accepted.
  task automatic send(input logic [31:0] w, input bit expect_issue);
    int n;
    n = 0;
    bus.ins_in       = w;
    bus.ins_valid_in = 1'b1;
    if (expect_issue) exp_q.push_back(w);
    @(negedge clock);
    while (!bus.ins_ready_out && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got ready=0 required ready=1 for %h", w);
    end
    @(posedge clock);
    #1;
    bus.ins_valid_in = 1'b0;
    $display("send %h", w);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_ins_out", bus.ins_out, 32'h0);
    chk("rst_valid_out", {31'h0, bus.ins_valid_out}, 32'h0);
    chk("rst_signal", {13'h0, signal_out}, 32'h0);
    chk("rst_pc_choice", {31'h0, pc_choice_out}, 32'h1);
    chk("rst_cu_enable", {31'h0, cu_enable_out}, 32'h0);
    chk("rst_comm_en", {31'h0, communication_enable_out}, 32'h0);
    chk("rst_state", {30'h0, state_out}, 32'h0);
    chk("rst_ready_out", {31'h0, bus.ins_ready_out}, 32'h1);
  endtask

  logic [31:0] start_w, stop_w, end_w;
  int base;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    start_w = ctrl(SUB_START, 17'h1ABCD); // 32'hFED5_E680, signal 19'h5ABCD
    stop_w  = ctrl(SUB_STOP,  17'h00042); // signal 19'h60042
    end_w   = ctrl(SUB_END,   17'h0BEEF); // signal 19'h0BEEF

    reset_n          = 1'b0;
    bus.ins_in       = '0;
    bus.ins_valid_in = 1'b0;
    bus.ins_ready_in = 1'b1;
    repeat (2) @(negedge clock);
    chk_reset_vals();
    reset_n = 1'b1;
    step(1);

    // Ordinary word in IDLE is buffered but not issued.
    send(32'h0000_1234, 1'b1);
    chk("idle_valid_out", {31'h0, bus.ins_valid_out}, 32'h0);
    chk("idle_state", {30'h0, state_out}, 32'h0);
    chk("idle_pc_choice", {31'h0, pc_choice_out}, 32'h1);

    // Start, then five ordinary words streamed with the CU ready.
    base = issue_cyc.size();
    send(start_w, 1'b0);
    chk("start_state", {30'h0, state_out}, 32'h1);
    chk("start_pc_choice", {31'h0, pc_choice_out}, 32'h0);
    chk("start_signal", {13'h0, signal_out}, 32'h0005_ABCD);
    chk("start_comm_held", {31'h0, communication_enable_out}, 32'h1);
    chk("start_cu_enable", {31'h0, cu_enable_out}, 32'h1);
    send(32'h0000_0101, 1'b1);
    chk("comm_clear_after_issue", {31'h0, communication_enable_out}, 32'h0);
    send(32'h0000_0202, 1'b1);
    send(32'h0000_0303, 1'b1);
    send(32'h0000_0404, 1'b1);
    send(32'h0000_0505, 1'b1);
    step(3);
    chk("burst_drained", exp_q.size(), 32'h0);
    if (issue_cyc.size() >= base + 6)
      chk("burst_no_bubbles", issue_cyc[base+5] - issue_cyc[base], 32'd5);
    else
      chk("burst_issue_count", issue_cyc.size() - base, 32'd6);

    // Fill to DEPTH with the CU stalled; a fifth word waits for a pop.
    bus.ins_ready_in = 1'b0;
    send(32'h1000_0000, 1'b1);
    send(32'h1000_0001, 1'b1);
    send(32'h1000_0002, 1'b1);
    chk("not_full_at_3", {31'h0, bus.ins_ready_out}, 32'h1);
    send(32'h1000_0003, 1'b1);
    chk("full_ready_low", {31'h0, bus.ins_ready_out}, 32'h0);
    bus.ins_in       = 32'h1000_0004;
    bus.ins_valid_in = 1'b1;
    exp_q.push_back(32'h1000_0004);
    step(2);
    chk("full_held", {31'h0, bus.ins_ready_out}, 32'h0);
    bus.ins_ready_in = 1'b1;
    step(1);
    bus.ins_ready_in = 1'b0;
    chk("ready_after_pop", {31'h0, bus.ins_ready_out}, 32'h1);
    step(1);
    bus.ins_valid_in = 1'b0;
    chk("fifth_accepted_full", {31'h0, bus.ins_ready_out}, 32'h0);
    bus.ins_ready_in = 1'b1;
    step(1);
    bus.ins_ready_in = 1'b0;
    chk("three_left", exp_q.size(), 32'd3);

    // Stop with three queued: CU off, queue frozen, two-cycle strobe.
    send(stop_w, 1'b0);
    bus.ins_ready_in = 1'b1;
    chk("stop_state", {30'h0, state_out}, 32'h2);
    chk("stop_cu_enable", {31'h0, cu_enable_out}, 32'h0);
    chk("stop_valid_out", {31'h0, bus.ins_valid_out}, 32'h0);
    chk("stop_signal", {13'h0, signal_out}, 32'h0006_0042);
    chk("pulse_cycle1", {31'h0, communication_enable_out}, 32'h1);
    step(1);
    chk("pulse_cycle2", {31'h0, communication_enable_out}, 32'h1);
    step(1);
    chk("pulse_over", {31'h0, communication_enable_out}, 32'h0);
    chk("halt_frozen", exp_q.size(), 32'd3);
    send(start_w, 1'b0);
    chk("resume_state", {30'h0, state_out}, 32'h1);
    step(5);
    chk("resume_drained", exp_q.size(), 32'h0);

    // End with two queued: flushed, DONE, later ordinary words dropped.
    bus.ins_ready_in = 1'b0;
    send(32'h2000_0000, 1'b0);
    send(32'h2000_0001, 1'b0);
    send(end_w, 1'b0);
    bus.ins_ready_in = 1'b1;
    chk("end_state", {30'h0, state_out}, 32'h3);
    chk("end_signal", {13'h0, signal_out}, 32'h0000_BEEF);
    chk("end_ready_out", {31'h0, bus.ins_ready_out}, 32'h1);
    chk("end_valid_out", {31'h0, bus.ins_valid_out}, 32'h0);
    chk("end_comm_held", {31'h0, communication_enable_out}, 32'h1);
    chk("end_cu_enable", {31'h0, cu_enable_out}, 32'h0);
`ifdef INS_ILLEGAL_DETECT_EN
    chk("illegal_before", {31'h0, illegal_out}, 32'h0);
`endif
    send(32'h2000_0002, 1'b0);
    step(3);
    chk("done_stays", {30'h0, state_out}, 32'h3);
    chk("done_ready_out", {31'h0, bus.ins_ready_out}, 32'h1);
`ifdef INS_ILLEGAL_DETECT_EN
    chk("illegal_after", {31'h0, illegal_out}, 32'h1);
`endif

    // Reset in the middle of a RUN burst.
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(1);
    bus.ins_ready_in = 1'b0;
    send(start_w, 1'b0);
    send(32'h3000_0000, 1'b0);
    send(32'h3000_0001, 1'b0);
    send(32'h3000_0002, 1'b0);
    chk("pre_reset_valid", {31'h0, bus.ins_valid_out}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk_reset_vals();
    step(2);
    reset_n = 1'b1;
    bus.ins_ready_in = 1'b1;
    step(1);
    send(start_w, 1'b0);
    chk("post_reset_empty", {31'h0, bus.ins_valid_out}, 32'h0);
    send(32'h0000_7777, 1'b1);
    step(3);
    chk("final_drained", exp_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
